square_out_buf: RTL and testbench

SQUARE_OUT_BUF -- requirements
Module: square_out_buf

---
 rtl/square_out_buf.sv | 100 ++++++++++
 tb/tb_square_out_buf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/square_out_buf.sv
// Result buffer for the square-root cell chain.
// Tracks launches through the fixed-latency cell chain with a valid shift
// register. Captures each result at the chain output into a show-ahead FIFO,
// and holds back launches with a credit counter so the FIFO can never overflow.
module square_out_buf #(
  parameter int WIDTH      = 4,
  parameter int LAT        = WIDTH,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  res_root,
  input  logic [2*WIDTH-1:0]                res_rem,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_root,
  output logic [2*WIDTH-1:0]                out_rem,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int DW = 3*WIDTH;

  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT:0]   vld_ext;
  logic [LW-1:0]  reserved_q, reserved_d;
  logic [LW-1:0]  level_q, level_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [DW-1:0]  head;
  logic           launch, pop, capture;

  // Handshakes, credit check and show-ahead head. Outputs are forced to 0 when
  // the FIFO is empty, so they read 0 while reset is held.
  always_comb begin
    in_ready  = (reserved_q < LW'(FIFO_DEPTH));
    out_valid = (level_q != '0);
    launch    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    capture   = vld_q[LAT-1];
    head      = out_valid ? mem_q[rptr_q] : '0;
    out_root  = head[DW-1:2*WIDTH];
    out_rem   = head[2*WIDTH-1:0];
    level     = level_q;
  end

  // Next-state for the valid pipe, credits, pointers and level.
  always_comb begin
    vld_ext = {vld_q, launch};
    vld_d   = vld_ext[LAT-1:0];

    reserved_d = reserved_q;
    case ({launch, pop})
      2'b10:   reserved_d = reserved_q + LW'(1);
      2'b01:   reserved_d = reserved_q - LW'(1);
      default: reserved_d = reserved_q;
    endcase

    level_d = level_q;
    case ({capture, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    wptr_d = capture ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop     ? rptr_q + AW'(1) : rptr_q;
  end

  // Control state. Reset drops everything in flight as well as everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      reserved_q <= '0;
      level_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      vld_q      <= vld_d;
      reserved_q <= reserved_d;
      level_q    <= level_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage. It has no reset; level gates its visibility.
  always_ff @(posedge clk) begin
    if (capture) mem_q[wptr_q] <= {res_root, res_rem};
  end

  // Credits must make a capture into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (level_q == LW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_square_out_buf.sv
// Bench for square_out_buf. A behavioural 4-stage register chain stands in
// for the square cells. A queue of expected results with visibility cycles
// serves as the reference for ordering, level, credits and data.
module tb_square_out_buf;
  localparam int WIDTH = 4;
  localparam int LAT   = 4;
  localparam int FD    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] res_root, out_root;
  logic [7:0]       res_rem, out_rem;
  logic [3:0]       level;
  logic [7:0]       rad;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] root;
    logic [7:0] rem;
    int         avail;
  } exp_t;
  exp_t q[$];

  square_out_buf #(.WIDTH(WIDTH), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .res_root(res_root), .res_rem(res_rem), .out_valid(out_valid),
    .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned isqrt(int unsigned x);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Square-cell chain stand-in: a registered result LAT edges after the radicand.
  logic [3:0] st_root [LAT];
  logic [7:0] st_rem  [LAT];
  always @(posedge clk) begin
    st_root[0] <= 4'(isqrt(32'(rad)));
    st_rem[0]  <= 8'(32'(rad) - isqrt(32'(rad)) * isqrt(32'(rad)));
    for (int i = 1; i < LAT; i++) begin
      st_root[i] <= st_root[i-1];
      st_rem[i]  <= st_rem[i-1];
    end
  end
  assign res_root = st_root[LAT-1];
  assign res_rem  = st_rem[LAT-1];

  // Reference model: the queue holds in-flight and buffered results. An entry becomes
  // visible LAT+1 cycles after the cycle in which it was launched.
  function automatic logic exp_valid();
    return (q.size() > 0) && (q[0].avail <= cyc);
  endfunction
  function automatic int exp_level();
    int n = 0;
    foreach (q[i]) if (q[i].avail <= cyc) n++;
    return n;
  endfunction
  function automatic logic exp_ready();
    return q.size() < FD;
  endfunction

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic drive_cycle(input logic iv, input logic [7:0] rd, input logic ordy);
    int cur;
    logic lch, pp;
    int unsigned r;
    in_valid  = iv;
    rad       = rd;
    out_ready = ordy;
    cur = cyc;
    lch = iv && exp_ready();
    pp  = ordy && exp_valid();
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (lch) begin
      r = isqrt(32'(rd));
      q.push_back('{4'(r), 8'(32'(rd) - r * r), cur + LAT + 1});
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; rad = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
    checks++; if (level !== 4'd0)     begin errors++; $display("FAIL reset level got %0d want 0", level); end
    checks++; if (out_root !== 4'd0)  begin errors++; $display("FAIL reset out_root got %0d want 0", out_root); end
    checks++; if (out_rem !== 8'd0)   begin errors++; $display("FAIL reset out_rem got %0d want 0", out_rem); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 8'd200, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b0, 8'($urandom), 1'b1);
      if (i == 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_nobypass out_valid got %0b want 0", out_valid); end
      end
      if (i == 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single out_valid got %0b want 1", out_valid); end
        checks++; if (out_root !== 4'd14) begin errors++; $display("FAIL single out_root got %0d want 14", out_root); end
        checks++; if (out_rem !== 8'd4)   begin errors++; $display("FAIL single out_rem got %0d want 4", out_rem); end
      end
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL single_model out_valid got %0b want %0b", out_valid, exp_valid()); end
      checks++; if (level !== 4'(exp_level())) begin errors++; $display("FAIL single_model level got %0d want %0d", level, exp_level()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rads [3];
    logic [3:0] want_root [3];
    logic [7:0] want_rem [3];
    logic [3:0] got_root [$];
    logic [7:0] got_rem [$];
    int first = -1, last = -1;
    rads = '{8'd255, 8'd0, 8'd1};
    want_root = '{4'd15, 4'd0, 4'd1};
    want_rem  = '{8'd30, 8'd0, 8'd0};
    for (int i = 0; i < 12; i++) begin
      if (i < 3) drive_cycle(1'b1, rads[i], 1'b1);
      else       drive_cycle(1'b0, 8'($urandom), 1'b1);
      if (out_valid === 1'b1) begin
        got_root.push_back(out_root);
        got_rem.push_back(out_rem);
        if (first < 0) first = i;
        last = i;
      end
      checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL b2b_model out_valid got %0b want %0b", out_valid, exp_valid()); end
    end
    checks++; if (got_root.size() != 3) begin errors++; $display("FAIL b2b count got %0d want 3", got_root.size()); end
    checks++; if (last - first != 2) begin errors++; $display("FAIL b2b consecutive span got %0d want 2", last - first); end
    for (int k = 0; k < 3 && k < got_root.size(); k++) begin
      checks++;
      if (got_root[k] !== want_root[k] || got_rem[k] !== want_rem[k]) begin
        errors++;
        $display("FAIL b2b result%0d got (%0d,%0d) want (%0d,%0d)", k, got_root[k], got_rem[k], want_root[k], want_rem[k]);
      end
    end
  endtask

  task automatic test_fill();
    int launches = 0;
    for (int i = 0; i < 14; i++) begin
      if (in_ready === 1'b1) launches++;
      drive_cycle(1'b1, 8'($urandom), 1'b0);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL fill in_ready got %0b want %0b", in_ready, exp_ready()); end
      checks++; if (level !== 4'(exp_level())) begin errors++; $display("FAIL fill level got %0d want %0d", level, exp_level()); end
    end
    checks++; if (launches != FD) begin errors++; $display("FAIL fill launches got %0d want %0d", launches, FD); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL fill final level got %0d want 8", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill final in_ready got %0b want 0", in_ready); end
  endtask

  task automatic check_model_cycle(input int phase);
    checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL run%0d in_ready got %0b want %0b", phase, in_ready, exp_ready()); end
    checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL run%0d out_valid got %0b want %0b", phase, out_valid, exp_valid()); end
    checks++; if (level !== 4'(exp_level())) begin errors++; $display("FAIL run%0d level got %0d want %0d", phase, level, exp_level()); end
    if (exp_valid()) begin
      checks++;
      if (out_root !== q[0].root || out_rem !== q[0].rem) begin
        errors++;
        $display("FAIL run%0d data got (%0d,%0d) want (%0d,%0d)", phase, out_root, out_rem, q[0].root, q[0].rem);
      end
    end
  endtask

  task automatic test_drain_wrap();
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'b1);
      check_model_cycle(1);
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
      check_model_cycle(2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      check_model_cycle(3);
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 8'($urandom), 1'b1);
      check_model_cycle(4);
    end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL random drained level got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
    drive_cycle(1'b0, 8'($urandom), 1'b0);
    drive_cycle(1'b0, 8'($urandom), 1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid async out_valid got %0b want 0", out_valid); end
    checks++; if (level !== 4'd0)     begin errors++; $display("FAIL rstmid async level got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid async in_ready got %0b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 8'($urandom), 1'b1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid got %0b want 0", out_valid); end
      checks++; if (level !== 4'd0)     begin errors++; $display("FAIL rstmid level got %0d want 0", level); end
      checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid in_ready got %0b want 1", in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_drain_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
